// File: rtl/logic_clk_ctrl.sv
// Purpose : drives clk_en for the logic-clock gate (clk & clk_en): halt, free-run, or exact N-cycle STEP burst.
// Latency : command accepted at posedge k -> busy after k, clk_en rises at the negedge after k, first gated edge at k+1.
// Backpressure: cmd_ready drops during a STEP burst, while halt_req is high and in reset; commands without ready are dropped.
//
// Ports:
//   clk, rst_n          - system clock (also the clock being gated), async active-low reset
//   halt_req            - level abort, highest priority, forces IDLE without step_done
//   cmd_valid/cmd_op    - command strobe and opcode (00 NOP, 01 HALT, 10 RUN, 11 STEP)
//   cmd_count           - number of gated pulses for STEP
//   cmd_ready           - combinational command accept
//   clk_en              - gate enable, launched on negedge clk so it only moves while clk is low
//   busy                - registered, high in RUN or STEP
//   step_done           - one-cycle pulse on normal STEP completion
//   remaining           - gated pulses still owed in STEP, 0 otherwise
module logic_clk_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             halt_req,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             cmd_ready,
  output logic             clk_en,
  output logic             busy,
  output logic             step_done,
  output logic [CNT_W-1:0] remaining
);

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_HALT = 2'b01;
  localparam logic [1:0] OP_RUN  = 2'b10;
  localparam logic [1:0] OP_STEP = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] rem_nxt;
  logic             done_nxt;
  logic             busy_nxt;
  logic             en_pos;
  logic             accept;

  // State register plus the posedge-registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      remaining <= '0;
      busy      <= 1'b0;
      step_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= rem_nxt;
      busy      <= busy_nxt;
      step_done <= done_nxt;
    end
  end

  // clk_en is launched on the falling edge: the gate's AND input is then
  // stable for the whole high phase, so no runt pulse can be produced.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_en <= 1'b0;
    end else begin
      clk_en <= en_pos;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    rem_nxt   = remaining;
    done_nxt  = 1'b0;
    if (halt_req) begin
      state_nxt = S_IDLE;
      rem_nxt   = '0;
    end else if (accept) begin
      case (cmd_op)
        OP_HALT: begin
          state_nxt = S_IDLE;
          rem_nxt   = '0;
        end
        OP_RUN: begin
          state_nxt = S_RUN;
          rem_nxt   = '0;
        end
        OP_STEP: begin
          if (cmd_count == '0) begin
            // Zero-length burst completes immediately with no gated pulse.
            state_nxt = S_IDLE;
            rem_nxt   = '0;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = S_STEP;
            rem_nxt   = cmd_count;
          end
        end
        default: begin
          state_nxt = state;
        end
      endcase
    end else if (state == S_STEP && clk_en) begin
      // clk_en high at this posedge means a gated pulse just happened.
      if (remaining == CNT_W'(1)) begin
        state_nxt = S_IDLE;
        rem_nxt   = '0;
        done_nxt  = 1'b1;
      end else if (remaining != '0) begin
        rem_nxt = remaining - CNT_W'(1);
      end
    end
  end

  // Output logic.
  always_comb begin
    cmd_ready = !halt_req && (state != S_STEP) && rst_n;
    accept    = cmd_valid && cmd_ready;
    en_pos    = (state == S_RUN) || (state == S_STEP);
    busy_nxt  = (state_nxt == S_RUN) || (state_nxt == S_STEP);
  end

endmodule

// File: tb/tb_logic_clk_ctrl.sv
// Purpose : directed bench for logic_clk_ctrl with a scoreboard queue of expected values.
// Latency : n/a.
// Backpressure: n/a.
module tb_logic_clk_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         halt_req = 1'b0;
  logic         cmd_valid = 1'b0;
  logic [1:0]   cmd_op = 2'b00;
  logic [W-1:0] cmd_count = '0;
  logic         cmd_ready;
  logic         clk_en;
  logic         busy;
  logic         step_done;
  logic [W-1:0] remaining;

  logic_clk_ctrl #(.CNT_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .halt_req  (halt_req),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_count (cmd_count),
    .cmd_ready (cmd_ready),
    .clk_en    (clk_en),
    .busy      (busy),
    .step_done (step_done),
    .remaining (remaining)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int exp_q[$];

  // Gated-clock edges, step_done pulses and any clk_en change while clk is high.
  int gated = 0;
  int done_cnt = 0;
  int runt = 0;
  always @(posedge clk) if (rst_n && clk_en) gated++;
  always @(posedge clk) if (rst_n && step_done) done_cnt++;
  always @(clk_en) if (rst_n && clk) runt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chkq(input string tag, input logic [31:0] obs);
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s: observed %0d expected <scoreboard empty>", tag, obs);
    end else begin
      chk(tag, obs, exp_q.pop_front());
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input int n);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = W'(n);
    cyc();
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_count = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int dbase;
    int lows;
    int guard;

    // ---- reset values ----
    #1 rst_n = 1'b0;
    #2;
    chk("rst_clk_en", clk_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_remaining", remaining, 0);
    chk("rst_step_done", step_done, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    repeat (2) cyc();
    @(negedge clk) rst_n = 1'b1;
    cyc();

    // ---- idle, no commands for 10 cycles ----
    base = gated;
    repeat (10) cyc();
    chk("idle_clk_en", clk_en, 0);
    chk("idle_busy", busy, 0);
    chk("idle_remaining", remaining, 0);
    chk("idle_cmd_ready", cmd_ready, 1);
    chk("idle_gated", gated - base, 0);

    // ---- STEP 5 from IDLE ----
    base = gated; dbase = done_cnt;
    for (int i = 5; i >= 0; i--) exp_q.push_back(i);
    exp_q.push_back(5);
    exp_q.push_back(1);
    send(2'b11, 5);
    chk("s5_busy", busy, 1);
    chk("s5_ready_in_step", cmd_ready, 0);
    chk("s5_clk_en_before_neg", clk_en, 0);
    chkq("s5_rem", remaining);
    @(negedge clk); #1;
    chk("s5_clk_en_rise", clk_en, 1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chkq("s5_rem", remaining);
    end
    chk("s5_step_done", step_done, 1);
    chk("s5_busy_fall", busy, 0);
    cyc();
    chk("s5_step_done_clear", step_done, 0);
    chk("s5_clk_en_fall", clk_en, 0);
    chkq("s5_gated", gated - base);
    chkq("s5_done_pulses", done_cnt - dbase);

    // ---- RUN for 20 cycles, then HALT ----
    base = gated;
    exp_q.push_back(21);
    send(2'b10, 0);
    chk("run_busy", busy, 1);
    chk("run_clk_en_before_neg", clk_en, 0);
    chk("run_remaining", remaining, 0);
    @(negedge clk); #1;
    chk("run_clk_en_rise", clk_en, 1);
    lows = 0;
    repeat (20) begin
      cyc();
      if (clk_en !== 1'b1) lows++;
    end
    chk("run_clk_en_continuous", lows, 0);
    send(2'b01, 0);
    chk("halt_busy", busy, 0);
    chk("halt_clk_en_held_high_phase", clk_en, 1);
    @(negedge clk); #1;
    chk("halt_clk_en_fall", clk_en, 0);
    cyc();
    chkq("run_gated", gated - base);

    // ---- STEP 0 then STEP 1 ----
    base = gated; dbase = done_cnt;
    exp_q.push_back(0);
    exp_q.push_back(1);
    send(2'b11, 0);
    chk("s0_busy", busy, 0);
    chk("s0_step_done", step_done, 1);
    cyc();
    chk("s0_step_done_clear", step_done, 0);
    chkq("s0_gated", gated - base);
    chkq("s0_done_pulses", done_cnt - dbase);

    base = gated; dbase = done_cnt;
    exp_q.push_back(1);
    exp_q.push_back(1);
    send(2'b11, 1);
    chk("s1_remaining", remaining, 1);
    chk("s1_step_done_early", step_done, 0);
    cyc();
    chk("s1_remaining_end", remaining, 0);
    chk("s1_step_done", step_done, 1);
    chk("s1_busy_fall", busy, 0);
    cyc();
    chkq("s1_gated", gated - base);
    chkq("s1_done_pulses", done_cnt - dbase);

    // ---- STEP 100 aborted by halt_req after 37 gated edges ----
    base = gated; dbase = done_cnt;
    exp_q.push_back(37);
    exp_q.push_back(63);
    exp_q.push_back(38);
    exp_q.push_back(0);
    send(2'b11, 100);
    guard = 0;
    while ((gated - base) < 37 && guard < 200) begin
      cyc();
      guard++;
    end
    chkq("abort_gated_pre", gated - base);
    chkq("abort_rem_pre", remaining);
    halt_req  = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    #1;
    chk("abort_ready_low", cmd_ready, 0);
    cyc();
    chk("abort_remaining", remaining, 0);
    chk("abort_busy", busy, 0);
    chk("abort_step_done", step_done, 0);
    @(negedge clk); #1;
    chk("abort_clk_en_fall", clk_en, 0);
    repeat (3) begin
      cyc();
      chk("abort_ready_held", cmd_ready, 0);
      chk("abort_run_ignored", busy, 0);
    end
    halt_req  = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cyc();
    chkq("abort_gated_total", gated - base);
    chkq("abort_no_done", done_cnt - dbase);

    // ---- reset mid-STEP at remaining = 12, then STEP 3 ----
    send(2'b11, 20);
    repeat (8) cyc();
    chk("mid_rem_12", remaining, 12);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_clk_en", clk_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_remaining", remaining, 0);
    chk("mid_rst_step_done", step_done, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 0);
    repeat (2) cyc();
    @(negedge clk) rst_n = 1'b1;
    cyc();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_ready", cmd_ready, 1);
    chk("post_rst_clk_en", clk_en, 0);
    base = gated; dbase = done_cnt;
    exp_q.push_back(3);
    exp_q.push_back(1);
    send(2'b11, 3);
    repeat (4) cyc();
    chkq("post_rst_s3_gated", gated - base);
    chkq("post_rst_s3_done", done_cnt - dbase);
    chk("post_rst_s3_busy", busy, 0);

    chk("no_runt_pulses", runt, 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
